mem_nr1w: RTL and testbench

MEM_NR1W -- requirements
Module: mem_nr1w

---
 rtl/mem_nr1w_pkg.sv | 11 +
 rtl/mem_nr1w_bank.sv | 29 ++
 rtl/mem_nr1w.sv | 126 ++++++++++++
 tb/tb_mem_nr1w.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/mem_nr1w_pkg.sv
// Shared types for mem_nr1w: sweep/run state encoding and the read-port ceiling.
package mem_nr1w_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  localparam int MAX_NRD = 8;

endpackage

// File: rtl/mem_nr1w_bank.sv
// One 1W1R synchronous-read array; read data registered, old data on same-address write.
// Read port holds its last output when re is low; no backpressure.
module mem_nr1w_bank #(
  parameter int    ADDRBIT = 9,
  parameter int    DEPTH   = 512,
  parameter int    WIDTH   = 32,
  parameter string TYPE    = "AUTO"
) (
  input  logic               clk,
  input  logic               we,
  input  logic [ADDRBIT-1:0] wa,
  input  logic [WIDTH-1:0]   di,
  input  logic               re,
  input  logic [ADDRBIT-1:0] ra,
  output logic [WIDTH-1:0]   q
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Named scope gives vendor flows a hook for a non-default inference hint.
  if (TYPE != "AUTO") begin : g_type_hint
  end

  always_ff @(posedge clk) begin
    if (we) mem[wa] <= di;
    if (re) q <= mem[ra];
  end

endmodule

// File: rtl/mem_nr1w.sv
// NRD-read / 1-write RAM that zero-sweeps itself after reset; read latency 1, no backpressure.
// MEM_NR1W_BYPASS_EN forwards same-cycle write data to colliding reads; otherwise read-before-write.
module mem_nr1w
  import mem_nr1w_pkg::*;
#(
  parameter int    ADDRBIT = 9,
  parameter int    DEPTH   = 512,
  parameter int    WIDTH   = 32,
  parameter int    NRD     = 2,
  parameter string TYPE    = "AUTO"
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ADDRBIT-1:0]     wa,
  input  logic                   we,
  input  logic [WIDTH-1:0]       di,
  input  logic [NRD-1:0]         re,
  input  logic [NRD*ADDRBIT-1:0] ra,
  output logic [NRD*WIDTH-1:0]   dout,
  output logic [NRD-1:0]         vld,
  output logic                   busy
);

  localparam logic [ADDRBIT:0]   DEPTH_W = (ADDRBIT+1)'(DEPTH);
  localparam logic [ADDRBIT-1:0] LAST    = ADDRBIT'(DEPTH - 1);

  state_t             state, state_nxt;
  logic [ADDRBIT-1:0] clr_ptr, clr_ptr_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_ptr <= '0;
    end else begin
      state   <= state_nxt;
      clr_ptr <= clr_ptr_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_ptr_nxt = clr_ptr;
    if (state == CLEAR) begin
      clr_ptr_nxt = clr_ptr + 1'b1;
      if (clr_ptr == LAST) begin
        state_nxt   = RUN;
        clr_ptr_nxt = '0;
      end
    end
  end

  assign busy = (state == CLEAR);

  logic               run;
  logic               wr_ok;
  logic               bank_we;
  logic [ADDRBIT-1:0] bank_wa;
  logic [WIDTH-1:0]   bank_di;

  // A cycle with rst high is treated as already back in CLEAR.
  assign run     = (state == RUN) && !rst;
  assign wr_ok   = run && we && ({1'b0, wa} < DEPTH_W);
  assign bank_we = busy || wr_ok;
  assign bank_wa = busy ? clr_ptr : wa;
  assign bank_di = busy ? '0 : di;

  for (genvar i = 0; i < NRD; i++) begin : g_port
    logic [ADDRBIT-1:0] rai;
    logic               rd_ok;
    logic               rd_in;
    logic [WIDTH-1:0]   q;
    logic               zero_q;
    logic               vld_q;

    assign rai   = ra[i*ADDRBIT +: ADDRBIT];
    assign rd_ok = run && re[i];
    assign rd_in = ({1'b0, rai} < DEPTH_W);

    mem_nr1w_bank #(
      .ADDRBIT (ADDRBIT),
      .DEPTH   (DEPTH),
      .WIDTH   (WIDTH),
      .TYPE    (TYPE)
    ) u_bank (
      .clk (clk),
      .we  (bank_we),
      .wa  (bank_wa),
      .di  (bank_di),
      .re  (rd_ok && rd_in),
      .ra  (rai),
      .q   (q)
    );

    // zero_q masks the bank output after reset and after out-of-range reads.
    always_ff @(posedge clk) begin
      if (rst) begin
        zero_q <= 1'b1;
        vld_q  <= 1'b0;
      end else begin
        vld_q <= rd_ok;
        if (rd_ok) zero_q <= !rd_in;
      end
    end

    assign vld[i] = vld_q;

`ifdef MEM_NR1W_BYPASS_EN
    logic             byp_q;
    logic [WIDTH-1:0] byp_dat;

    always_ff @(posedge clk) begin
      if (rst) begin
        byp_q <= 1'b0;
      end else if (rd_ok) begin
        byp_q   <= wr_ok && (wa == rai);
        byp_dat <= di;
      end
    end

    assign dout[i*WIDTH +: WIDTH] = zero_q ? '0 : (byp_q ? byp_dat : q);
`else
    assign dout[i*WIDTH +: WIDTH] = zero_q ? '0 : q;
`endif
  end

endmodule

// File: tb/tb_mem_nr1w.sv
// Directed bench for mem_nr1w: a 16-deep 4-port instance and a 12-deep 1-port instance share reset.
module tb_mem_nr1w;

  localparam int AB = 4;
  localparam int D  = 16;
  localparam int W  = 32;
  localparam int N  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [AB-1:0] wa;
  logic          we;
  logic [W-1:0]  di;
  logic [N-1:0]  re;
  logic [N*AB-1:0] ra;
  logic [N*W-1:0]  dout;
  logic [N-1:0]  vld;
  logic          busy;

  logic [3:0]    s_wa;
  logic          s_we;
  logic [31:0]   s_di;
  logic [0:0]    s_re;
  logic [3:0]    s_ra;
  logic [31:0]   s_dout;
  logic [0:0]    s_vld;
  logic          s_busy;

  mem_nr1w #(.ADDRBIT(AB), .DEPTH(D), .WIDTH(W), .NRD(N), .TYPE("AUTO")) dut (
    .clk(clk), .rst(rst), .wa(wa), .we(we), .di(di), .re(re), .ra(ra),
    .dout(dout), .vld(vld), .busy(busy)
  );

  mem_nr1w #(.ADDRBIT(4), .DEPTH(12), .WIDTH(32), .NRD(1), .TYPE("AUTO")) dut_s (
    .clk(clk), .rst(rst), .wa(s_wa), .we(s_we), .di(s_di), .re(s_re), .ra(s_ra),
    .dout(s_dout), .vld(s_vld), .busy(s_busy)
  );

`ifdef MEM_NR1W_BYPASS_EN
  localparam logic [31:0] COLLIDE_EXP = 32'h12345678;
`else
  localparam logic [31:0] COLLIDE_EXP = 32'hAAAA5555;
`endif

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cnt;
  int          s_cnt;
  logic [31:0] mdl [D];
  logic [31:0] exp_d;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; wa = '0; di = '0; re = '0; ra = '0;
    s_we = 1'b0; s_wa = '0; s_di = '0; s_re = '0; s_ra = '0;
    for (int k = 0; k < D; k++) mdl[k] = '0;

    step; step;
    chk("rst_busy",  128'(busy),   128'(1));
    chk("rst_vld",   128'(vld),    128'(0));
    chk("rst_dout",  dout,         128'(0));
    chk("rst_sbusy", 128'(s_busy), 128'(1));

    // Sweep: reads requested throughout must be ignored.
    re = '1; ra = {N{4'd2}}; s_re = 1'b1;
    rst = 1'b0; cnt = 0; s_cnt = 0;
    while (busy && cnt < 40) begin
      step;
      cnt++;
      chk("clr_vld", 128'(vld), 128'(0));
      if (!s_busy && s_cnt == 0) begin
        s_cnt = cnt;
        s_re  = 1'b0;
      end
    end
    chk("busy_len",   128'(cnt),   128'(16));
    chk("s_busy_len", 128'(s_cnt), 128'(12));

    // Every address on every port reads zero, back to back.
    for (int a = 0; a < D; a++) begin
      re = '1;
      ra = {4'(a + 3), 4'(a + 2), 4'(a + 1), 4'(a)};
      step;
      chk("clr_rd_vld", 128'(vld), 128'(4'hF));
      chk("clr_rd_dat", dout,      128'(0));
    end
    re = '0;
    step;
    chk("vld_pulse", 128'(vld), 128'(0));

    // Write then broadcast read.
    we = 1'b1; wa = 4'd5; di = 32'hDEADBEEF; mdl[5] = 32'hDEADBEEF;
    step;
    we = 1'b0; re = '1; ra = {N{4'd5}};
    step;
    chk("bcast_dat", dout,      {N{32'hDEADBEEF}});
    chk("bcast_vld", 128'(vld), 128'(4'hF));

    // Same-cycle read/write collision on address 3.
    re = '0; we = 1'b1; wa = 4'd3; di = 32'hAAAA5555;
    step;
    we = 1'b1; wa = 4'd3; di = 32'h12345678; mdl[3] = 32'h12345678;
    re = 4'b0011; ra = {4'd0, 4'd0, 4'd5, 4'd3};
    step;
    chk("collide_p0", 128'(dout[31:0]),  128'(COLLIDE_EXP));
    chk("collide_p1", 128'(dout[63:32]), 128'(32'hDEADBEEF));
    we = 1'b0; re = 4'b0001; ra = {12'd0, 4'd3};
    step;
    chk("after_wr", 128'(dout[31:0]), 128'(32'h12345678));
    re = '0; ra = {12'd0, 4'd7};
    step;
    chk("hold_dat", 128'(dout[31:0]), 128'(32'h12345678));
    chk("hold_vld", 128'(vld),        128'(0));

    // 12-deep instance: out-of-range write dropped, out-of-range read returns zero.
    s_we = 1'b1; s_wa = 4'd11; s_di = 32'hCAFE0011;
    step;
    s_wa = 4'd13; s_di = 32'hFFFFFFFF;
    step;
    s_we = 1'b0; s_re = 1'b1; s_ra = 4'd13;
    step;
    chk("oor_dat", 128'(s_dout), 128'(0));
    chk("oor_vld", 128'(s_vld),  128'(1));
    s_ra = 4'd11;
    step;
    chk("oor_a11", 128'(s_dout), 128'(32'hCAFE0011));
    s_ra = 4'd1;
    step;
    chk("oor_a1", 128'(s_dout), 128'(0));
    s_ra = 4'd0;
    step;
    chk("oor_a0", 128'(s_dout), 128'(0));
    s_re = 1'b0;

    // Streaming: write address i while port 0 reads address i-1.
    for (int i = 0; i < D; i++) begin
      we = 1'b1; wa = 4'(i); di = 32'h100 + 32'(i);
      re = 4'b0001; ra = {12'd0, 4'(i - 1)};
      exp_d = mdl[4'(i - 1)];
      step;
      mdl[i] = 32'h100 + 32'(i);
      chk("stream_vld", 128'(vld),        128'(4'b0001));
      chk("stream_dat", 128'(dout[31:0]), 128'(exp_d));
    end
    we = 1'b0; re = '0;
    step;

    // Reset with reads in flight, then reset again mid-sweep.
    re = '1; ra = {N{4'd5}}; rst = 1'b1;
    step;
    chk("rst_if_vld",  128'(vld),  128'(0));
    chk("rst_if_dat",  dout,       128'(0));
    chk("rst_if_busy", 128'(busy), 128'(1));
    rst = 1'b0;
    repeat (7) step;
    chk("mid_busy", 128'(busy), 128'(1));
    rst = 1'b1;
    step;
    chk("mid_rst_busy", 128'(busy), 128'(1));
    rst = 1'b0; cnt = 0;
    while (busy && cnt < 40) begin
      step;
      cnt++;
      chk("mid_clr_vld", 128'(vld), 128'(0));
    end
    chk("restart_len", 128'(cnt), 128'(16));
    re = '1; ra = {4'd15, 4'd10, 4'd7, 4'd0};
    step;
    chk("reclr_dat", dout,      128'(0));
    chk("reclr_vld", 128'(vld), 128'(4'hF));
    re = '0;
    step;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
